// File: rtl/filter_out_serializer.sv
// Output serializer for an L=3 parallel filter: each accepted block of three 64-bit
// accumulator samples is rounded, shifted and saturated to 32 bits, queued in a block
// FIFO, then streamed out one sample per transfer in y_in0, y_in1, y_in2 order.
module filter_out_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SHIFT = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic signed [63:0] y_in0,
  input  logic signed [63:0] y_in1,
  input  logic signed [63:0] y_in2,
  output logic signed [31:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               sat_flag,
  input  logic               sat_clr,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(DEPTH);

  // Returns {saturated, sample}: round half up, arithmetic shift, clamp to 32 bits.
  function automatic logic [32:0] convert(input logic signed [63:0] y);
    logic signed [64:0] t;
    logic signed [64:0] r;
    t = $signed({y[63], y}) + (65'sd1 <<< (SHIFT - 1));
    r = t >>> SHIFT;
    // In range exactly when every bit above bit 31 matches the sign bit.
    if ((r[64:31] == '0) || (r[64:31] == '1)) begin
      convert = {1'b0, r[31:0]};
    end else begin
      convert = {1'b1, (r[64] ? 32'h8000_0000 : 32'h7fff_ffff)};
    end
  endfunction

  logic [31:0]       mem_q [DEPTH][3];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]        ph_q, ph_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              sat_q, sat_d;

  logic [32:0] c0, c1, c2;
  logic        accept, xfer, pop, any_sat;

  // Per-sample conversion and handshake decode.
  always_comb begin
    c0         = convert(y_in0);
    c1         = convert(y_in1);
    c2         = convert(y_in2);
    any_sat    = c0[32] | c1[32] | c2[32];
    blk_ready  = (level_q != LevelW'(DEPTH));
    dout_valid = (level_q != '0);
    accept     = blk_valid & blk_ready;
    xfer       = dout_valid & dout_ready;
    pop        = xfer & (ph_q == 2'd2);
  end

  // Next-state for pointers, phase, occupancy and the sticky saturation flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ph_d     = ph_q;
    level_d  = level_q;
    sat_d    = sat_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (xfer) begin
      ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({accept, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
    if (sat_clr) begin
      sat_d = 1'b0;
    end
    // A saturating accept overrides a coincident clear.
    if (accept && any_sat) begin
      sat_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ph_q     <= '0;
      level_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ph_q     <= ph_d;
      level_q  <= level_d;
      sat_q    <= sat_d;
    end
  end

  // Block storage; contents are only meaningful below level, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q][0] <= c0[31:0];
      mem_q[wr_ptr_q][1] <= c1[31:0];
      mem_q[wr_ptr_q][2] <= c2[31:0];
    end
  end

  // Output taps: head entry selected by phase, forced to 0 when empty.
  always_comb begin
    dout     = dout_valid ? $signed(mem_q[rd_ptr_q][ph_q]) : 32'sd0;
    sat_flag = sat_q;
    level    = level_q;
  end

endmodule

// File: tb/tb_filter_out_serializer.sv
// Self-checking bench for filter_out_serializer: directed scenarios with random data,
// compared every cycle against a sample-queue reference model.
module tb_filter_out_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SHIFT = 31;

  logic               clk;
  logic               rst;
  logic               blk_valid;
  logic               blk_ready;
  logic signed [63:0] y_in0, y_in1, y_in2;
  logic signed [31:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               sat_flag;
  logic               sat_clr;
  logic [2:0]         level;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Reference model: flat queue of pending output samples plus sticky flag.
  logic [31:0] mq[$];
  logic        msat;

  filter_out_serializer #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .rst        (rst),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .y_in0      (y_in0),
    .y_in1      (y_in1),
    .y_in2      (y_in2),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag),
    .sat_clr    (sat_clr),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rounded division by 2^SHIFT with floor semantics, then clamp: {sat, value}.
  function automatic logic [32:0] model_conv(input logic signed [63:0] y);
    logic signed [127:0] t, p2, q;
    p2 = 128'sd1 <<< SHIFT;
    t  = y;
    t  = t + (p2 / 128'sd2);
    q  = t / p2;
    if ((t < 0) && (q * p2 != t)) q = q - 128'sd1;
    if (q > 128'sd2147483647)       return {1'b1, 32'h7fff_ffff};
    else if (q < -128'sd2147483648) return {1'b1, 32'h8000_0000};
    else                            return {1'b0, q[31:0]};
  endfunction

  function automatic logic signed [63:0] rand_y();
    logic signed [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = {$urandom, $urandom};
      1:       v = 64'($signed($urandom)) <<< $urandom_range(0, 31);
      2:       v = (64'sd2147483647 <<< 31) + 64'($signed($urandom_range(0, 1 << 31)));
      default: v = -(64'sd2147483648 <<< 31) - 64'($signed($urandom_range(0, 1 << 31)));
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_rand();
    y_in0 = rand_y();
    y_in1 = rand_y();
    y_in2 = rand_y();
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic step();
    int unsigned lvl;
    logic        acc, s;
    logic [32:0] r0, r1, r2;
    if (rst) begin
      #1;
      mq.delete();
      msat = 1'b0;
    end
    lvl = (mq.size() + 2) / 3;
    chk("level", 64'(lvl), {61'b0, level});
    chk("blk_ready", {63'b0, blk_ready}, 64'(lvl != DEPTH));
    chk("dout_valid", {63'b0, dout_valid}, 64'(mq.size() != 0));
    chk("dout", {32'b0, dout}, (mq.size() != 0) ? {32'b0, mq[0]} : 64'd0);
    chk("sat_flag", {63'b0, sat_flag}, {63'b0, msat});
    @(posedge clk);
    if (!rst) begin
      acc = blk_valid && (lvl != DEPTH);
      r0  = model_conv(y_in0);
      r1  = model_conv(y_in1);
      r2  = model_conv(y_in2);
      s   = r0[32] | r1[32] | r2[32];
      if (dout_ready && (mq.size() != 0)) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(r0[31:0]);
        mq.push_back(r1[31:0]);
        mq.push_back(r2[31:0]);
      end
      if (acc && s)     msat = 1'b1;
      else if (sat_clr) msat = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    blk_valid  = 1'b0;
    dout_ready = 1'b0;
    sat_clr    = 1'b0;
    y_in0      = '0;
    y_in1      = '0;
    y_in2      = '0;
    msat       = 1'b0;
    @(posedge clk);
    #1;
    step();
    chk("rst_dout", {32'b0, dout}, 64'd0);
    rst = 1'b0;

    // Known-answer rounding block.
    dout_ready = 1'b1;
    y_in0 = 64'sd2147483648;
    y_in1 = 64'sd3221225472;
    y_in2 = -64'sd1073741824;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("kat_a0", {32'b0, dout}, 64'd1);
    step();
    chk("kat_a1", {32'b0, dout}, 64'd2);
    step();
    chk("kat_a2", {32'b0, dout}, 64'd0);
    step();
    chk("kat_a_sat", {63'b0, sat_flag}, 64'd0);

    // Known-answer saturation block and sticky flag.
    y_in0 = 64'sh4000_0000_0000_0000;
    y_in1 = 64'sh8000_0000_0000_0000;
    y_in2 = 64'sd0;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("kat_b0", {32'b0, dout}, 64'h7fff_ffff);
    step();
    chk("kat_b1", {32'b0, dout}, 64'h8000_0000);
    step();
    chk("kat_b2", {32'b0, dout}, 64'd0);
    step();
    step();
    chk("sat_sticky", {63'b0, sat_flag}, 64'd1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_cleared", {63'b0, sat_flag}, 64'd0);
    step();

    // Fill to full with downstream stalled, then drain.
    dout_ready = 1'b0;
    blk_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put_rand();
      step();
    end
    blk_valid = 1'b0;
    chk("full_level", {61'b0, level}, 64'd4);
    chk("full_ready", {63'b0, blk_ready}, 64'd0);
    dout_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("drained", {61'b0, level}, 64'd0);

    // Random stalls with blocks offered every cycle.
    for (int i = 0; i < 400; i++) begin
      put_rand();
      blk_valid  = 1'b1;
      dout_ready = ($urandom_range(0, 3) != 0);
      sat_clr    = ($urandom_range(0, 15) == 0);
      step();
    end
    blk_valid  = 1'b0;
    dout_ready = 1'b1;
    sat_clr    = 1'b0;
    for (int i = 0; i < 3 * DEPTH + 3; i++) step();

    // Reset with two blocks held and the head partially drained.
    dout_ready = 1'b0;
    blk_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put_rand();
      step();
    end
    blk_valid  = 1'b0;
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    step();
    chk("pre_rst_level", {61'b0, level}, 64'd2);
    rst = 1'b1;
    step();
    chk("rst_valid", {63'b0, dout_valid}, 64'd0);
    rst = 1'b0;
    put_rand();
    blk_valid  = 1'b1;
    dout_ready = 1'b1;
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Accept coincident with final-sample pop at level 3, across pointer wrap.
    rst = 1'b1;
    step();
    rst        = 1'b0;
    dout_ready = 1'b0;
    blk_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_rand();
      step();
    end
    blk_valid  = 1'b0;
    dout_ready = 1'b1;
    step();
    step();
    put_rand();
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("wrap_level", {61'b0, level}, 64'd3);
    for (int i = 0; i < 12; i++) step();
    chk("wrap_drained", {61'b0, level}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
